inst_fetch_unit: RTL and testbench

//  Sequences the combinational instMem: owns the program counter, drives instMem.address, captures instMem.inst.

---
 rtl/inst_fetch_unit.sv | 82 ++++++++
 tb/tb_inst_fetch_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: drives instMem from the PC, buffers fetched words with their PCs in a small queue,
// and hands them to decode over valid/ready; execute redirects flush the queue and reload the PC.
module inst_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     halt,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_inst,
    output logic                     if_valid,
    output logic [31:0]              if_inst,
    output logic [31:0]              if_pc,
    input  logic                     id_ready,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic [1:0]               fetch_state,
    output logic [$clog2(DEPTH):0]   q_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HALT = 2'b10} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   last_inst, last_pc;
    logic          push, pop;

    assign pop         = if_valid && id_ready && !redirect_valid;
    assign push        = state == RUN && !halt && !redirect_valid && (count < FULL || pop);
    assign imem_addr   = pc;
    assign if_valid    = count != '0;
    assign if_inst     = if_valid ? q_inst[rd_ptr] : last_inst;
    assign if_pc       = if_valid ? q_pc[rd_ptr] : last_pc;
    assign q_count     = count;
    assign fetch_state = state;

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= imem_inst;
            q_pc[wr_ptr]   <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            last_inst <= '0;
            last_pc   <= '0;
        end else begin
            state <= ((state == IDLE && start) || (state == HALT && !halt)) ? RUN :
                     (state == RUN && halt && !redirect_valid) ? HALT : state;
            if (if_valid) begin
                last_inst <= q_inst[rd_ptr];
                last_pc   <= q_pc[rd_ptr];
            end
            if (redirect_valid) begin
                pc     <= redirect_pc;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                pc     <= push ? pc + 32'd1 : pc;
                rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
                wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
                count  <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed and random stimulus against a queue-based reference model of the fetch unit.
module tb_inst_fetch_unit;
    localparam int DEPTH = 4;

    logic        clk = 0, rst_n = 0, start = 0, halt = 0, id_ready = 0, redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic [31:0] imem_addr, imem_inst, if_inst, if_pc;
    logic        if_valid;
    logic [1:0]  fetch_state;
    logic [2:0]  q_count;

    inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .imem_addr(imem_addr), .imem_inst(imem_inst),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .id_ready(id_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_state(fetch_state), .q_count(q_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'd0:   return 32'd205520897;
            32'd1:   return 32'd203423744;
            32'd2:   return 32'd203456512;
            32'd10:  return 32'd1541406720;
            default: return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
        endcase
    endfunction

    assign imem_inst = word_at(imem_addr);

    typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc, m_last_pc, m_last_inst;
    int          m_st;
    int          vectors = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("imem_addr", imem_addr, m_pc);
        check("if_valid", 32'(if_valid), 32'(mq.size() > 0));
        check("if_pc", if_pc, mq.size() > 0 ? mq[0].pc : m_last_pc);
        check("if_inst", if_inst, mq.size() > 0 ? mq[0].inst : m_last_inst);
        check("q_count", 32'(q_count), 32'(mq.size()));
        check("fetch_state", 32'(fetch_state), 32'(m_st));
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = 0; m_last_pc = 0; m_last_inst = 0; m_st = 0;
    endtask

    // Applies one cycle of inputs (called at a falling edge), advances the model, checks after the rising edge.
    task automatic cycle(input logic s, input logic h, input logic r, input logic rv, input logic [31:0] rp);
        bit valid, pop, push;
        int nst;
        start = s; halt = h; id_ready = r; redirect_valid = rv; redirect_pc = rp;
        valid = mq.size() > 0;
        if (valid) begin
            m_last_pc   = mq[0].pc;
            m_last_inst = mq[0].inst;
        end
        if (rv) begin
            mq.delete();
            m_pc = rp;
        end else begin
            pop  = valid && r;
            push = m_st == 1 && !h && (mq.size() < DEPTH || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{m_pc, word_at(m_pc)});
                m_pc = m_pc + 1;
            end
        end
        nst = m_st;
        if (m_st == 0 && s) nst = 1;
        if (m_st == 1 && h && !rv) nst = 2;
        if (m_st == 2 && !h) nst = 1;
        m_st = nst;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        start = 0; halt = 0; id_ready = 0; redirect_valid = 0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        do_reset();
        // sequential fetch from reset
        cycle(1, 0, 1, 0, 0);
        check("start_addr", imem_addr, 32'd0);
        cycle(0, 0, 1, 0, 0);
        check("seq_pc0", if_pc, 32'd0);
        check("seq_inst0", if_inst, 32'd205520897);
        cycle(0, 0, 1, 0, 0);
        check("seq_pc1", if_pc, 32'd1);
        check("seq_inst1", if_inst, 32'd203423744);
        cycle(0, 0, 1, 0, 0);
        check("seq_pc2", if_pc, 32'd2);
        check("seq_inst2", if_inst, 32'd203456512);
        // fill to DEPTH with decode stalled
        do_reset();
        cycle(1, 0, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 0, 0);
        check("full_count", 32'(q_count), 32'd4);
        check("full_pc", imem_addr, 32'd4);
        for (int i = 1; i <= 2; i++) begin
            cycle(0, 0, 1, 0, 0);
            check("stream_count", 32'(q_count), 32'd4);
            check("stream_pc", if_pc, 32'(i));
        end
        // redirect with coincident ready: head not consumed, queue flushed
        cycle(0, 0, 1, 1, 32'd10);
        check("redir_valid", 32'(if_valid), 32'd0);
        check("redir_count", 32'(q_count), 32'd0);
        check("redir_addr", imem_addr, 32'd10);
        cycle(0, 0, 1, 0, 0);
        check("redir_pc", if_pc, 32'd10);
        check("redir_inst", if_inst, 32'd1541406720);
        // halt with three queued
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("pre_halt_count", 32'(q_count), 32'd3);
        cycle(0, 1, 0, 0, 0);
        check("halt_state", 32'(fetch_state), 32'd2);
        repeat (4) cycle(0, 1, 1, 0, 0);
        check("halt_drained", 32'(if_valid), 32'd0);
        check("halt_pc", imem_addr, 32'd13);
        cycle(0, 0, 1, 0, 0);
        check("resume_state", 32'(fetch_state), 32'd1);
        cycle(0, 0, 1, 0, 0);
        check("resume_pc", if_pc, 32'd13);
        // PC wrap
        cycle(0, 0, 1, 1, 32'hFFFFFFFF);
        cycle(0, 0, 1, 0, 0);
        check("wrap_addr", imem_addr, 32'd0);
        check("wrap_head", if_pc, 32'hFFFFFFFF);
        // random traffic with occasional mid-stream resets
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 300; n++) begin
                logic [31:0] rp;
                rp = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - $urandom_range(0, 2) : $urandom;
                cycle($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7,
                      $urandom_range(0, 15) == 0, rp);
            end
            do_reset();
            check("mid_reset_valid", 32'(if_valid), 32'd0);
            if (k < 2) cycle(1, 0, 0, 0, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
